// File: rtl/bram_array.sv
// -----------------------------------------------------------------------------
// bram_array
//
// Parametrised block-RAM array for the iCE40. NUM_BLOCKS logical blocks of
// 256 words, each DATA_WIDTH bits wide, built from 256x16 RAM primitives
// placed side by side (DATA_WIDTH/16 primitives per logical block).
//
// Features:
//   - registered read port with a one-cycle rd_valid strobe
//   - write-first forwarding when a read and a write hit the same address in
//     the same cycle
//   - out-of-range block select detection (addr_err) for non-power-of-two
//     NUM_BLOCKS
//   - optional hardware clear sequencer, built only when the macro
//     BRAM_ARRAY_CLEAR_EN is defined
//
// Parameters:
//   NUM_BLOCKS  number of logical 256-word blocks (1..32)
//   DATA_WIDTH  word width, multiple of 16 (16..64)
//   SEL_BITS    derived block-select width, max(1, clog2(NUM_BLOCKS))
//   AW          derived address width, 8 + SEL_BITS
//
// Ports:
//   clk        in   single clock, all logic on the rising edge
//   rst_n      in   synchronous active-low reset
//   rd_en      in   read request, accepted when busy=0
//   rd_addr    in   read address, [AW-1:8] block select, [7:0] word
//   wr_en      in   write request, accepted when busy=0
//   wr_addr    in   write address, same split as rd_addr
//   data_in    in   write data
//   data_out   out  read data, valid with rd_valid, held between reads
//   rd_valid   out  one-cycle strobe per accepted read
//   addr_err   out  one-cycle strobe for an accepted out-of-range access
//   clear_req  in   start a clear sequence (clear builds only)
//   busy       out  clear in progress, requests are dropped
// -----------------------------------------------------------------------------
module bram_array #(
    parameter  int NUM_BLOCKS = 16,
    parameter  int DATA_WIDTH = 16,
    localparam int SEL_BITS   = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1,
    localparam int AW         = 8 + SEL_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  addr_err,
    input  logic                  clear_req,
    output logic                  busy
);

    localparam int NUM_PRIMS = DATA_WIDTH / 16;

    // One extra bit so the limit itself is representable even when
    // NUM_BLOCKS is a power of two.
    localparam logic [SEL_BITS:0] SEL_LIMIT = (SEL_BITS + 1)'(NUM_BLOCKS);

    // Clear sequencer view shared by the datapath: while clearing is high
    // every primitive is written with zero at clearAddr.
    logic       clearing;
    logic [7:0] clearAddr;

`ifdef BRAM_ARRAY_CLEAR_EN
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clrState_t;

    clrState_t  state_q, state_d;
    logic [7:0] clrCnt_q, clrCnt_d;
    logic       autoClr_q, autoClr_d;

    // Clear sequencer state. Reset parks the FSM in IDLE with the auto-clear
    // flag armed so that the first cycle after release starts a full sweep;
    // a reset in the middle of a sweep therefore aborts and restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            clrCnt_q  <= '0;
            autoClr_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            clrCnt_q  <= clrCnt_d;
            autoClr_q <= autoClr_d;
        end
    end

    // Next-state logic. clear_req is only looked at in IDLE, so a request
    // during a sweep neither restarts nor extends it.
    always_comb begin
        state_d   = state_q;
        clrCnt_d  = clrCnt_q;
        autoClr_d = autoClr_q;
        case (state_q)
            ST_IDLE: begin
                if (autoClr_q || clear_req) begin
                    state_d   = ST_CLEAR;
                    clrCnt_d  = '0;
                    autoClr_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                clrCnt_d = clrCnt_q + 8'd1;
                if (clrCnt_q == 8'hFF) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign clearing  = (state_q == ST_CLEAR);
    assign clearAddr = clrCnt_q;
    assign busy      = clearing;
`else
    // Without the sequencer the RAMs keep their bitstream contents and the
    // clear request has no effect.
    logic unusedClearReq;

    assign clearing       = 1'b0;
    assign clearAddr      = '0;
    assign busy           = 1'b0;
    assign unusedClearReq = clear_req;
`endif

    // Request qualification and address decode.
    logic                rdAcc, wrAcc;
    logic                rdOob, wrOob;
    logic [SEL_BITS-1:0] rdSel, wrSel;

    assign rdSel = rd_addr[AW-1:8];
    assign wrSel = wr_addr[AW-1:8];
    assign rdAcc = rd_en && !clearing;
    assign wrAcc = wr_en && !clearing;
    assign rdOob = ({1'b0, rdSel} >= SEL_LIMIT);
    assign wrOob = ({1'b0, wrSel} >= SEL_LIMIT);

    // Shared write port of all primitives: the clear sweep owns it while
    // active, otherwise the requester does.
    logic [7:0]            memWAddr;
    logic [DATA_WIDTH-1:0] memWData;
    logic                  ramRe;
    logic [NUM_BLOCKS-1:0] blkWe;

    assign memWAddr = clearing ? clearAddr : wr_addr[7:0];
    assign memWData = clearing ? '0 : data_in;
    assign ramRe    = rdAcc && !rdOob;

    logic [DATA_WIDTH-1:0] ramRd [NUM_BLOCKS];

    // Block array. Each logical block gets its own one-hot write enable so a
    // normal write touches exactly one block; the clear sweep enables all of
    // them. Each primitive registers its read word and keeps it until the
    // next accepted read, which is what makes data_out hold between reads.
    for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_block
        assign blkWe[b] = clearing ||
                          (wrAcc && !wrOob && (wrSel == SEL_BITS'(b)));

        for (genvar p = 0; p < NUM_PRIMS; p++) begin : g_prim
            logic [15:0] mem [256];
            logic [15:0] rdWord_q;

            // One 256x16 primitive: synchronous write, registered read.
            always_ff @(posedge clk) begin
                if (blkWe[b]) begin
                    mem[memWAddr] <= memWData[p*16 +: 16];
                end
                if (ramRe) begin
                    rdWord_q <= mem[rd_addr[7:0]];
                end
            end

            assign ramRd[b][p*16 +: 16] = rdWord_q;
        end
    end

    // Read-side pipeline registers. The block select, out-of-range flag and
    // forwarding decision travel alongside the RAM access so the output mux
    // lines up with the word that comes back one cycle later.
    logic                  rdValid_q, rdValid_d;
    logic                  addrErr_q, addrErr_d;
    logic                  haveData_q, haveData_d;
    logic [SEL_BITS-1:0]   rdSel_q, rdSel_d;
    logic                  rdOob_q, rdOob_d;
    logic                  fwd_q, fwd_d;
    logic [DATA_WIDTH-1:0] fwdData_q, fwdData_d;

    // Next-state for the read pipeline. Only an accepted read updates the
    // steering state; a read and a write in the same cycle raise a single
    // addr_err pulse even when both are out of range.
    always_comb begin
        rdValid_d  = rdAcc;
        addrErr_d  = (rdAcc && rdOob) || (wrAcc && wrOob);
        haveData_d = haveData_q;
        rdSel_d    = rdSel_q;
        rdOob_d    = rdOob_q;
        fwd_d      = fwd_q;
        fwdData_d  = fwdData_q;
        if (rdAcc) begin
            haveData_d = 1'b1;
            rdSel_d    = rdSel;
            rdOob_d    = rdOob;
            fwd_d      = wrAcc && (wr_addr == rd_addr);
            fwdData_d  = data_in;
        end
    end

    // Read pipeline registers; haveData_q forces data_out to zero from
    // reset until the first read returns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdValid_q  <= 1'b0;
            addrErr_q  <= 1'b0;
            haveData_q <= 1'b0;
            rdSel_q    <= '0;
            rdOob_q    <= 1'b0;
            fwd_q      <= 1'b0;
            fwdData_q  <= '0;
        end else begin
            rdValid_q  <= rdValid_d;
            addrErr_q  <= addrErr_d;
            haveData_q <= haveData_d;
            rdSel_q    <= rdSel_d;
            rdOob_q    <= rdOob_d;
            fwd_q      <= fwd_d;
            fwdData_q  <= fwdData_d;
        end
    end

    // Output mux: out-of-range reads return zero, a same-address write in the
    // read cycle wins over the stale RAM word, otherwise the selected block.
    logic [DATA_WIDTH-1:0] muxData;

    always_comb begin
        muxData = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (rdSel_q == SEL_BITS'(i)) begin
                muxData = ramRd[i];
            end
        end
    end

    always_comb begin
        data_out = muxData;
        if (!haveData_q || rdOob_q) begin
            data_out = '0;
        end else if (fwd_q) begin
            data_out = fwdData_q;
        end
    end

    assign rd_valid = rdValid_q;
    assign addr_err = addrErr_q;

endmodule

// File: tb/tb_bram_array.sv
// -----------------------------------------------------------------------------
// tb_bram_array
//
// Self-checking bench for bram_array with NUM_BLOCKS=12 (non-power-of-two)
// and DATA_WIDTH=32 (two primitives per block). A table of one-cycle vectors
// covers writes, reads, forwarding, holding and out-of-range handling; hand
// sequences cover reset and, when BRAM_ARRAY_CLEAR_EN is defined, the clear
// sequencer including abort by reset.
// -----------------------------------------------------------------------------
module tb_bram_array;

    localparam int NB = 12;
    localparam int DW = 32;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic          addr_err;
    logic          clear_req;
    logic          busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bram_array #(
        .NUM_BLOCKS(NB),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .data_in  (data_in),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .addr_err (addr_err),
        .clear_req(clear_req),
        .busy     (busy)
    );

    typedef struct {
        logic          wrEn;
        logic [AW-1:0] wrAddr;
        logic [DW-1:0] wrData;
        logic          rdEn;
        logic [AW-1:0] rdAddr;
        logic          expValid;
        logic [DW-1:0] expData;
        logic          expErr;
    } vec_t;

    vec_t vecs[$];

    task automatic setIdle();
        rd_en     = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        data_in   = '0;
        clear_req = 1'b0;
    endtask

    task automatic addVec(input logic wrEn, input logic [AW-1:0] wrAddr,
                          input logic [DW-1:0] wrData, input logic rdEn,
                          input logic [AW-1:0] rdAddr, input logic expValid,
                          input logic [DW-1:0] expData, input logic expErr);
        vec_t v;
        v.wrEn     = wrEn;
        v.wrAddr   = wrAddr;
        v.wrData   = wrData;
        v.rdEn     = rdEn;
        v.rdAddr   = rdAddr;
        v.expValid = expValid;
        v.expData  = expData;
        v.expErr   = expErr;
        vecs.push_back(v);
    endtask

    task automatic checkValue(input string name, input logic [DW-1:0] got,
                              input logic [DW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Drive one vector for one cycle; returns at the following negedge,
    // where the outputs reflect that vector.
    task automatic applyStimulus(input vec_t v);
        wr_en   = v.wrEn;
        wr_addr = v.wrAddr;
        data_in = v.wrData;
        rd_en   = v.rdEn;
        rd_addr = v.rdAddr;
        @(negedge clk);
        setIdle();
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkValue({tag, " rd_valid"}, DW'(rd_valid), DW'(v.expValid));
        checkValue({tag, " data_out"}, data_out, v.expData);
        checkValue({tag, " addr_err"}, DW'(addr_err), DW'(v.expErr));
        checkValue({tag, " busy"}, DW'(busy), '0);
    endtask

    task automatic doWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        vec_t v;
        v = '{1'b1, addr, data, 1'b0, '0, 1'b0, '0, 1'b0};
        applyStimulus(v);
    endtask

    task automatic doRead(input string tag, input logic [AW-1:0] addr,
                          input logic [DW-1:0] expData, input logic expErr);
        vec_t v;
        v = '{1'b0, '0, '0, 1'b1, addr, 1'b1, expData, expErr};
        applyStimulus(v);
        checkOutput(tag, v);
    endtask

`ifdef BRAM_ARRAY_CLEAR_EN
    // Count consecutive busy cycles starting at the current negedge. With
    // inject set, requests are fired into the busy window; abortAt > 0 drops
    // rst_n once that many busy cycles have been seen.
    task automatic measureBusy(input bit inject, input int abortAt, output int len,
                               output bit sawValid, output bit sawErr);
        len      = 0;
        sawValid = 1'b0;
        sawErr   = 1'b0;
        while (busy === 1'b1 && len < 400) begin
            if (rd_valid === 1'b1) sawValid = 1'b1;
            if (addr_err === 1'b1) sawErr = 1'b1;
            len++;
            if (abortAt != 0 && len == abortAt) begin
                setIdle();
                rst_n = 1'b0;
                return;
            end
            rd_en     = inject && (len == 10);
            rd_addr   = '0;
            wr_en     = inject && (len == 20 || len == 30);
            wr_addr   = (len == 20) ? 12'h005 : 12'hC00;
            data_in   = 32'h5555_5555;
            clear_req = inject && (len == 50);
            @(negedge clk);
        end
        setIdle();
    endtask
`endif

    task automatic doReset(input string tag);
        int len;
        bit sawValid;
        bit sawErr;
        len      = 0;
        sawValid = 1'b0;
        sawErr   = 1'b0;
        rst_n = 1'b0;
        setIdle();
        repeat (3) @(negedge clk);
        checkValue({tag, " reset data_out"}, data_out, '0);
        checkValue({tag, " reset rd_valid"}, DW'(rd_valid), '0);
        checkValue({tag, " reset addr_err"}, DW'(addr_err), '0);
        checkValue({tag, " reset busy"}, DW'(busy), '0);
        rst_n = 1'b1;
        @(negedge clk);
`ifdef BRAM_ARRAY_CLEAR_EN
        checkValue({tag, " auto-clear busy rise"}, DW'(busy), 32'd1);
        measureBusy(1'b0, 0, len, sawValid, sawErr);
        checkValue({tag, " auto-clear length"}, DW'(len), 32'd256);
`else
        checkValue({tag, " busy after release"}, DW'(busy), '0);
`endif
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
`ifdef BRAM_ARRAY_CLEAR_EN
        int len;
        bit sawValid;
        bit sawErr;
`endif
        rst_n = 1'b0;
        setIdle();
        doReset("init");

        //     wr  wrAddr   wrData        rd  rdAddr   vld data          err
        addVec(1, 12'h305, 32'h0000BEEF, 0, 12'h000, 0, 32'h00000000, 0);
        addVec(0, 12'h000, 32'h00000000, 1, 12'h305, 1, 32'h0000BEEF, 0);
        addVec(0, 12'h000, 32'h00000000, 0, 12'h000, 0, 32'h0000BEEF, 0);
        addVec(1, 12'h0FF, 32'h12345678, 0, 12'h000, 0, 32'h0000BEEF, 0);
        addVec(1, 12'h1FF, 32'hDEADBEEF, 0, 12'h000, 0, 32'h0000BEEF, 0);
        addVec(0, 12'h000, 32'h00000000, 1, 12'h0FF, 1, 32'h12345678, 0);
        addVec(0, 12'h000, 32'h00000000, 1, 12'h1FF, 1, 32'hDEADBEEF, 0);
        addVec(0, 12'h000, 32'h00000000, 0, 12'h000, 0, 32'hDEADBEEF, 0);
        addVec(1, 12'h042, 32'h0000A5A5, 1, 12'h042, 1, 32'h0000A5A5, 0);
        addVec(0, 12'h000, 32'h00000000, 1, 12'h042, 1, 32'h0000A5A5, 0);
        addVec(1, 12'h010, 32'h00001111, 0, 12'h000, 0, 32'h0000A5A5, 0);
        addVec(1, 12'h810, 32'h22223333, 0, 12'h000, 0, 32'h0000A5A5, 0);
        addVec(1, 12'h410, 32'h44445555, 0, 12'h000, 0, 32'h0000A5A5, 0);
        addVec(1, 12'hC10, 32'h00001111, 0, 12'h000, 0, 32'h0000A5A5, 1);
        addVec(0, 12'h000, 32'h00000000, 1, 12'hC10, 1, 32'h00000000, 1);
        addVec(0, 12'h000, 32'h00000000, 1, 12'h010, 1, 32'h00001111, 0);
        addVec(0, 12'h000, 32'h00000000, 1, 12'h810, 1, 32'h22223333, 0);
        addVec(0, 12'h000, 32'h00000000, 1, 12'h410, 1, 32'h44445555, 0);
        addVec(1, 12'hB00, 32'h0BADF00D, 1, 12'h305, 1, 32'h0000BEEF, 0);
        addVec(0, 12'h000, 32'h00000000, 1, 12'hB00, 1, 32'h0BADF00D, 0);
        addVec(1, 12'hD01, 32'h99999999, 1, 12'hE02, 1, 32'h00000000, 1);
        addVec(0, 12'h000, 32'h00000000, 0, 12'h000, 0, 32'h00000000, 0);
        addVec(1, 12'h305, 32'h11112222, 1, 12'h305, 1, 32'h11112222, 0);
        addVec(0, 12'h000, 32'h00000000, 1, 12'hF05, 1, 32'h00000000, 1);
        addVec(0, 12'h000, 32'h00000000, 1, 12'h305, 1, 32'h11112222, 0);
        addVec(0, 12'h000, 32'h00000000, 1, 12'h0FF, 1, 32'h12345678, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
        end

`ifdef BRAM_ARRAY_CLEAR_EN
        // Clear with requests fired into the busy window.
        doWrite(12'h000, 32'h00000001);
        doWrite(12'h3FF, 32'hFFFFFFFF);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        checkValue("clear busy rise", DW'(busy), 32'd1);
        measureBusy(1'b1, 0, len, sawValid, sawErr);
        checkValue("clear length", DW'(len), 32'd256);
        checkValue("rd_valid during busy", DW'(sawValid), '0);
        checkValue("addr_err during busy", DW'(sawErr), '0);
        doRead("after clear 0x000", 12'h000, 32'h0, 1'b0);
        doRead("after clear 0x3FF", 12'h3FF, 32'h0, 1'b0);
        doRead("dropped write 0x005", 12'h005, 32'h0, 1'b0);

        // Reset in the middle of a sweep, then a fresh auto-clear.
        doWrite(12'h0FF, 32'h77777777);
        doWrite(12'h000, 32'h88888888);
        doRead("pre-abort 0x0FF", 12'h0FF, 32'h77777777, 1'b0);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        measureBusy(1'b0, 100, len, sawValid, sawErr);
        checkValue("abort point", DW'(len), 32'd100);
        doReset("abort");
        doRead("after abort 0x0FF", 12'h0FF, 32'h0, 1'b0);
        doRead("after abort 0x000", 12'h000, 32'h0, 1'b0);
`else
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        checkValue("clear_req ignored busy", DW'(busy), '0);
        doRead("contents kept 0x305", 12'h305, 32'h11112222, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
